// File: rtl/pulse_burst_detector_if.sv
// Signal bundle between a pulse source (master) and the burst detector (slave).
// burst_valid is a one-cycle strobe with no ready: results are taken that cycle or read later from the held outputs.
interface pulse_burst_detector_if #(
  parameter int WIDTH_BITS = 8,
  parameter int COUNT_BITS = 4
);
  logic                  signal;
  logic                  burst_valid;
  logic [COUNT_BITS-1:0] burst_count;
  logic [WIDTH_BITS-1:0] high_width;
  logic [WIDTH_BITS-1:0] low_width;
  logic                  overflow;
  logic                  busy;
  logic [1:0]            state;

  modport master (
    output signal,
    input  burst_valid, burst_count, high_width, low_width, overflow, busy, state
  );

  modport slave (
    input  signal,
    output burst_valid, burst_count, high_width, low_width, overflow, busy, state
  );
endinterface

// File: rtl/pulse_burst_detector.sv
// Measures pulse count, last high width and last low gap of a burst on an
// asynchronous pulse line; reports once the line has stayed low for GAP_CYCLES.
module pulse_burst_detector #(
  parameter int WIDTH_BITS = 8,
  parameter int COUNT_BITS = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  pulse_burst_detector_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2, DONE = 2'd3} state_t;

  localparam logic [WIDTH_BITS-1:0] W_MAX    = '1;
  localparam logic [COUNT_BITS-1:0] C_MAX    = '1;
  localparam logic [WIDTH_BITS-1:0] W_ONE    = WIDTH_BITS'(1);
  localparam logic [COUNT_BITS-1:0] C_ONE    = COUNT_BITS'(1);
  localparam logic [WIDTH_BITS-1:0] GAP_LAST = WIDTH_BITS'(GAP_CYCLES - 1);

  state_t                state;
  logic                  s1, s2, s_prev;
  logic [WIDTH_BITS-1:0] hi_cnt, lo_cnt, hi_last, lo_last;
  logic [COUNT_BITS-1:0] pcnt;
  logic                  ovf_int;

  logic                  burst_valid_r;
  logic [COUNT_BITS-1:0] burst_count_r;
  logic [WIDTH_BITS-1:0] high_width_r, low_width_r;
  logic                  overflow_r;

  logic rise, fall;
  assign rise = s2 & ~s_prev;
  assign fall = ~s2 & s_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      s1            <= 1'b0;
      s2            <= 1'b0;
      s_prev        <= 1'b0;
      hi_cnt        <= '0;
      lo_cnt        <= '0;
      hi_last       <= '0;
      lo_last       <= '0;
      pcnt          <= '0;
      ovf_int       <= 1'b0;
      burst_valid_r <= 1'b0;
      burst_count_r <= '0;
      high_width_r  <= '0;
      low_width_r   <= '0;
      overflow_r    <= 1'b0;
    end else begin
      s1            <= bus.signal;
      s2            <= s1;
      s_prev        <= s2;
      burst_valid_r <= 1'b0;
      case (state)
        // DONE lasts one cycle but accepts a new burst exactly like IDLE.
        IDLE, DONE: begin
          if (rise) begin
            hi_cnt  <= W_ONE;
            pcnt    <= C_ONE;
            lo_last <= '0;
            ovf_int <= 1'b0;
            state   <= HIGH;
          end else begin
            state   <= IDLE;
          end
        end
        HIGH: begin
          if (fall) begin
            hi_last <= hi_cnt;
            lo_cnt  <= W_ONE;
            state   <= LOW;
          end else if (s2 && hi_cnt != W_MAX) begin
            hi_cnt <= hi_cnt + W_ONE;
            if (hi_cnt == W_MAX - W_ONE) ovf_int <= 1'b1;
          end
        end
        LOW: begin
          if (!s2) begin
            if (lo_cnt == GAP_LAST) begin
              state         <= DONE;
              burst_valid_r <= 1'b1;
              burst_count_r <= pcnt;
              high_width_r  <= hi_last;
              low_width_r   <= lo_last;
              overflow_r    <= ovf_int;
            end else if (lo_cnt != W_MAX) begin
              lo_cnt <= lo_cnt + W_ONE;
              if (lo_cnt == W_MAX - W_ONE) ovf_int <= 1'b1;
            end
          end else begin
            // s2 high while in LOW is always a rising edge.
            lo_last <= lo_cnt;
            hi_cnt  <= W_ONE;
            if (pcnt != C_MAX) begin
              pcnt <= pcnt + C_ONE;
              if (pcnt == C_MAX - C_ONE) ovf_int <= 1'b1;
            end
            state   <= HIGH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.burst_valid = burst_valid_r;
  assign bus.burst_count = burst_count_r;
  assign bus.high_width  = high_width_r;
  assign bus.low_width   = low_width_r;
  assign bus.overflow    = overflow_r;
  assign bus.busy        = (state == HIGH) || (state == LOW);
  assign bus.state       = state;

endmodule

// File: tb/tb_pulse_burst_detector.sv
// Bench for pulse_burst_detector: directed scenarios plus random bursts checked
// against a run-length model of the delayed pulse line.
module tb_pulse_burst_detector;
  localparam int W   = 8;
  localparam int C   = 4;
  localparam int GAP = 16;
  localparam int RW  = C + 2 * W + 1;
  localparam int WMAX = (1 << W) - 1;
  localparam int CMAX = (1 << C) - 1;

  typedef struct packed {
    logic [C-1:0] cnt;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ovf;
  } res_t;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   edge_cnt = 0;
  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  pulse_burst_detector_if #(.WIDTH_BITS(W), .COUNT_BITS(C)) bus ();

  pulse_burst_detector #(.WIDTH_BITS(W), .COUNT_BITS(C), .GAP_CYCLES(GAP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: line level seen two edges late, tracked as runs
  logic [RW-1:0] exp_q[$];
  logic          exp_valid = 1'b0;
  res_t          held_m    = '0;
  int h1 = 0, h2 = 0, yprev = 0, in_burst = 0;
  int pulses = 0, hi_run = 0, lo_run = 0, hi_last_m = 0, lo_last_m = 0, ovf_m = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clock) begin : model
    int   y;
    res_t r;
    exp_valid = 1'b0;
    if (reset) begin
      h1 = 0; h2 = 0; yprev = 0; in_burst = 0; held_m = '0;
    end else begin
      y  = h2;
      h2 = h1;
      h1 = int'(bus.signal);
      if (!in_burst) begin
        if (y == 1 && yprev == 0) begin
          in_burst = 1; pulses = 1; hi_run = 1; lo_run = 0;
          hi_last_m = 0; lo_last_m = 0; ovf_m = 0;
        end
      end else if (y == 1) begin
        if (yprev == 0) begin
          lo_last_m = lo_run; pulses++; hi_run = 1;
        end else hi_run++;
      end else begin
        if (yprev == 1) begin
          hi_last_m = hi_run; lo_run = 1;
        end else lo_run++;
      end
      if (in_burst && (hi_run >= WMAX || lo_run >= WMAX || pulses >= CMAX)) ovf_m = 1;
      if (in_burst && y == 0 && lo_run == GAP) begin
        r.cnt = C'(sat(pulses, CMAX));
        r.hi  = W'(sat(hi_last_m, WMAX));
        r.lo  = W'(sat(lo_last_m, WMAX));
        r.ovf = (ovf_m != 0);
        exp_q.push_back(r);
        held_m    = r;
        exp_valid = 1'b1;
        in_burst  = 0;
      end
      yprev = y;
    end
  end

  // scoreboard / monitor
  res_t res_log[$];
  int   edge_log[$];
  int   n_bursts = 0;

  always @(negedge clock) begin : monitor
    res_t obs, e;
    obs = {bus.burst_count, bus.high_width, bus.low_width, bus.overflow};
    chk("valid", 32'(bus.burst_valid), 32'(exp_valid));
    chk("busy", 32'(bus.busy), in_burst);
    chk("held", 32'(obs), 32'(held_m));
    if (bus.burst_valid === 1'b1) begin
      chk("burst_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("burst_result", 32'(obs), 32'(e));
      end
      res_log.push_back(obs);
      edge_log.push_back(edge_cnt);
      n_bursts++;
    end
  end

  // drivers
  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.signal = v;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    hold(1'b1, hi);
    hold(1'b0, lo);
  endtask

  task automatic wait_bursts(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && n_bursts < target; i++) @(negedge clock);
    @(negedge clock);
    chk(tag, 32'(n_bursts >= target), 1);
  endtask

  int b0, e0;

  initial begin
    bus.signal = 1'b0;
    reset      = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_valid", 32'(bus.burst_valid), 0);
    chk("reset_busy",  32'(bus.busy), 0);
    chk("reset_count", 32'(bus.burst_count), 0);
    chk("reset_state", 32'(bus.state), 0);

    // normal burst
    b0 = n_bursts;
    pulse(4, 4); pulse(4, 4); hold(1'b1, 4);
    @(negedge clock); bus.signal = 1'b0; e0 = edge_cnt + 1;
    wait_bursts("normal_timeout", b0 + 1, 60);
    if (n_bursts > b0) begin
      chk("normal_count", 32'(res_log[b0].cnt), 3);
      chk("normal_hi",    32'(res_log[b0].hi), 4);
      chk("normal_lo",    32'(res_log[b0].lo), 4);
      chk("normal_ovf",   32'(res_log[b0].ovf), 0);
      chk("normal_latency", 32'(edge_log[b0] - e0), 17);
    end
    hold(1'b0, 5);

    // single pulse
    b0 = n_bursts;
    hold(1'b1, 6); hold(1'b0, 1);
    wait_bursts("single_timeout", b0 + 1, 60);
    if (n_bursts > b0) begin
      chk("single_count", 32'(res_log[b0].cnt), 1);
      chk("single_hi",    32'(res_log[b0].hi), 6);
      chk("single_lo",    32'(res_log[b0].lo), 0);
    end

    // gap boundary: 15 low keeps burst open, 16 low closes it
    b0 = n_bursts;
    pulse(3, 15); hold(1'b1, 3); hold(1'b0, 1);
    wait_bursts("gap15_timeout", b0 + 1, 60);
    if (n_bursts > b0) begin
      chk("gap15_count", 32'(res_log[b0].cnt), 2);
      chk("gap15_lo",    32'(res_log[b0].lo), 15);
    end
    hold(1'b0, 20);
    b0 = n_bursts;
    pulse(3, 16); hold(1'b1, 3); hold(1'b0, 1);
    wait_bursts("gap16_timeout", b0 + 2, 80);
    if (n_bursts > b0 + 1) begin
      chk("gap16_count_a", 32'(res_log[b0].cnt), 1);
      chk("gap16_count_b", 32'(res_log[b0 + 1].cnt), 1);
    end
    hold(1'b0, 20);

    // saturation
    b0 = n_bursts;
    hold(1'b1, 300);
    chk("sat_no_valid", n_bursts, b0);
    chk("sat_busy", 32'(bus.busy), 1);
    hold(1'b0, 1);
    wait_bursts("sat_hi_timeout", b0 + 1, 60);
    if (n_bursts > b0) begin
      chk("sat_hi",     32'(res_log[b0].hi), 255);
      chk("sat_hi_ovf", 32'(res_log[b0].ovf), 1);
    end
    hold(1'b0, 10);
    b0 = n_bursts;
    for (int i = 0; i < 20; i++) pulse(2, 2);
    wait_bursts("sat_cnt_timeout", b0 + 1, 60);
    if (n_bursts > b0) begin
      chk("sat_count",     32'(res_log[b0].cnt), 15);
      chk("sat_count_ovf", 32'(res_log[b0].ovf), 1);
    end
    hold(1'b0, 5);

    // reset during second pulse of a burst
    b0 = n_bursts;
    pulse(3, 3); hold(1'b1, 2);
    @(negedge clock); reset = 1'b1; bus.signal = 1'b0;
    @(negedge clock); reset = 1'b0;
    chk("rst_mid_valid", 32'(bus.burst_valid), 0);
    chk("rst_mid_busy",  32'(bus.busy), 0);
    chk("rst_mid_count", 32'(bus.burst_count), 0);
    chk("rst_mid_hi",    32'(bus.high_width), 0);
    chk("rst_mid_ovf",   32'(bus.overflow), 0);
    hold(1'b0, 30);
    chk("rst_mid_no_burst", n_bursts, b0);
    pulse(3, 3); hold(1'b1, 3); hold(1'b0, 1);
    wait_bursts("rst_after_timeout", b0 + 1, 60);
    if (n_bursts > b0) chk("rst_after_count", 32'(res_log[b0].cnt), 2);
    hold(1'b0, 10);

    // back-to-back: next rise lands in the DONE cycle
    b0 = n_bursts;
    pulse(2, 2); hold(1'b1, 2); hold(1'b0, 16);
    pulse(5, 2); hold(1'b1, 5); hold(1'b0, 1);
    wait_bursts("b2b_timeout", b0 + 2, 80);
    if (n_bursts > b0 + 1) begin
      chk("b2b_count_a", 32'(res_log[b0].cnt), 2);
      chk("b2b_hi_a",    32'(res_log[b0].hi), 2);
      chk("b2b_count_b", 32'(res_log[b0 + 1].cnt), 2);
      chk("b2b_hi_b",    32'(res_log[b0 + 1].hi), 5);
      chk("b2b_lo_b",    32'(res_log[b0 + 1].lo), 2);
    end
    hold(1'b0, 10);

    // random bursts, judged cycle by cycle by the monitor
    for (int k = 0; k < 25; k++) begin
      int np;
      np = $urandom_range(1, 6);
      for (int p = 0; p < np; p++) pulse($urandom_range(1, 10), $urandom_range(1, 18));
      hold(1'b0, $urandom_range(16, 24));
    end
    hold(1'b0, 40);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
